// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the program-memory address,
// and loads the fetched word plus PC+4 into the IF/ID pipeline register.
module fetch_stage #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0004_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall,
  input  logic                  Redirect,
  input  logic [DATA_WIDTH-1:0] RedirectTarget,
  input  logic [DATA_WIDTH-1:0] Instruction_ROM,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] IFID_Instruction,
  output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
  output logic                  IFID_Valid,
  output logic                  Fault
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Window bounds carry one extra bit so RESET_PC + 4*MEMORY_DEPTH cannot wrap.
  localparam logic [DATA_WIDTH:0] WIN_LO = {1'b0, RESET_PC};
  localparam logic [DATA_WIDTH:0] WIN_HI = {1'b0, RESET_PC} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [DATA_WIDTH-1:0]   pcplus4_q, pcplus4_d;
  logic                    valid_q, valid_d;
  logic                    fault_q, fault_d;
  logic [DATA_WIDTH-1:0]   pc_plus4_s;
  logic                    target_bad_s;
  logic                    advance_bad_s;

  function automatic logic fetch_addr_bad(input logic [DATA_WIDTH-1:0] addr);
    logic [DATA_WIDTH:0] wide;
    wide = {1'b0, addr};
    return (addr[1:0] != 2'b00) || (wide < WIN_LO) || (wide >= WIN_HI);
  endfunction

  assign pc_plus4_s    = pc_q + DATA_WIDTH'(3'd4);
  assign target_bad_s  = fetch_addr_bad(RedirectTarget);
  assign advance_bad_s = fetch_addr_bad(pc_plus4_s);

  // Next-state logic: redirect beats stall beats advance; any bad next PC halts fetch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    case (state_q)
      ST_BOOT: begin
        state_d   = ST_RUN;
        instr_d   = '0;
        pcplus4_d = '0;
        valid_d   = 1'b0;
        if (Redirect) begin
          if (target_bad_s) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d = RedirectTarget;
          end
        end else begin
          pc_d = pc_q;
        end
      end
      ST_RUN: begin
        if (Redirect) begin
          instr_d   = '0;
          pcplus4_d = '0;
          valid_d   = 1'b0;
          if (target_bad_s) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d = RedirectTarget;
          end
        end else if (Stall) begin
          pc_d = pc_q;
        end else begin
          // The word at PC is valid even when stepping past the window end.
          instr_d   = Instruction_ROM;
          pcplus4_d = pc_plus4_s;
          valid_d   = 1'b1;
          if (advance_bad_s) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d = pc_plus4_s;
          end
        end
      end
      ST_HALT: begin
        instr_d   = '0;
        pcplus4_d = '0;
        valid_d   = 1'b0;
        fault_d   = 1'b1;
      end
      default: begin
        state_d   = ST_HALT;
        instr_d   = '0;
        pcplus4_d = '0;
        valid_d   = 1'b0;
        fault_d   = 1'b1;
      end
    endcase
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
    end
  end

  assign PC               = pc_q;
  assign IFID_Instruction = instr_q;
  assign IFID_PCPlus4     = pcplus4_q;
  assign IFID_Valid       = valid_q;
  assign Fault            = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a 32-word instance for the main flow and a
// 4-word instance for window-end and below-window fault cases.
module tb_fetch_stage;

  localparam logic [31:0] BASE = 32'h0004_0000;
  localparam logic [31:0] SIG  = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst_a, stall_a, redir_a;
  logic [31:0] tgt_a, rom_a, pc_a, ir_a, pp4_a;
  logic        val_a, flt_a;
  logic        rst_b, stall_b, redir_b;
  logic [31:0] tgt_b, rom_b, pc_b, ir_b, pp4_b;
  logic        val_b, flt_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // ROM model: word index tagged with a signature.
  assign rom_a = SIG + ((pc_a - BASE) >> 2);
  assign rom_b = SIG + ((pc_b - BASE) >> 2);

  fetch_stage #(.DATA_WIDTH(32), .MEMORY_DEPTH(32), .RESET_PC(BASE)) dut_a (
    .clk(clk), .reset(rst_a), .Stall(stall_a), .Redirect(redir_a),
    .RedirectTarget(tgt_a), .Instruction_ROM(rom_a), .PC(pc_a),
    .IFID_Instruction(ir_a), .IFID_PCPlus4(pp4_a), .IFID_Valid(val_a), .Fault(flt_a)
  );

  fetch_stage #(.DATA_WIDTH(32), .MEMORY_DEPTH(4), .RESET_PC(BASE)) dut_b (
    .clk(clk), .reset(rst_b), .Stall(stall_b), .Redirect(redir_b),
    .RedirectTarget(tgt_b), .Instruction_ROM(rom_b), .PC(pc_b),
    .IFID_Instruction(ir_b), .IFID_PCPlus4(pp4_b), .IFID_Valid(val_b), .Fault(flt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_a(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                       input logic [31:0] pp4, input logic v, input logic f);
    check({tag, ".pc"}, pc_a, pc);
    check({tag, ".ir"}, ir_a, ir);
    check({tag, ".pp4"}, pp4_a, pp4);
    check({tag, ".valid"}, {31'd0, val_a}, {31'd0, v});
    check({tag, ".fault"}, {31'd0, flt_a}, {31'd0, f});
  endtask

  task automatic chk_b(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                       input logic [31:0] pp4, input logic v, input logic f);
    check({tag, ".pc"}, pc_b, pc);
    check({tag, ".ir"}, ir_b, ir);
    check({tag, ".pp4"}, pp4_b, pp4);
    check({tag, ".valid"}, {31'd0, val_b}, {31'd0, v});
    check({tag, ".fault"}, {31'd0, flt_b}, {31'd0, f});
  endtask

  initial begin
    rst_a = 1'b0; stall_a = 1'b0; redir_a = 1'b0; tgt_a = 32'd0;
    rst_b = 1'b0; stall_b = 1'b0; redir_b = 1'b0; tgt_b = 32'd0;
    #12;
    chk_a("reset", BASE, 32'd0, 32'd0, 1'b0, 1'b0);

    // Test 1: boot then free run
    @(negedge clk); rst_a = 1'b1;
    tick(); chk_a("boot", BASE, 32'd0, 32'd0, 1'b0, 1'b0);
    tick(); chk_a("run0", 32'h0004_0004, SIG + 32'd0, 32'h0004_0004, 1'b1, 1'b0);
    tick(); chk_a("run1", 32'h0004_0008, SIG + 32'd1, 32'h0004_0008, 1'b1, 1'b0);

    // Test 2: two stalled edges at 40008
    stall_a = 1'b1;
    tick(); chk_a("stall1", 32'h0004_0008, SIG + 32'd1, 32'h0004_0008, 1'b1, 1'b0);
    tick(); chk_a("stall2", 32'h0004_0008, SIG + 32'd1, 32'h0004_0008, 1'b1, 1'b0);
    stall_a = 1'b0;
    tick(); chk_a("resume", 32'h0004_000C, SIG + 32'd2, 32'h0004_000C, 1'b1, 1'b0);

    // Test 3: redirect wins over stall, one bubble
    redir_a = 1'b1; stall_a = 1'b1; tgt_a = 32'h0004_0010;
    tick(); chk_a("redir", 32'h0004_0010, 32'd0, 32'd0, 1'b0, 1'b0);
    redir_a = 1'b0; stall_a = 1'b0;
    tick(); chk_a("postredir", 32'h0004_0014, SIG + 32'd4, 32'h0004_0014, 1'b1, 1'b0);

    // Test 4: misaligned redirect faults, later redirect ignored
    redir_a = 1'b1; tgt_a = 32'h0004_0012;
    tick(); chk_a("misalign", 32'h0004_0014, 32'd0, 32'd0, 1'b0, 1'b1);
    tgt_a = BASE;
    tick(); chk_a("halt", 32'h0004_0014, 32'd0, 32'd0, 1'b0, 1'b1);
    redir_a = 1'b0;
    tick(); chk_a("halt2", 32'h0004_0014, 32'd0, 32'd0, 1'b0, 1'b1);

    // Test 6: async reset mid-cycle while halted; BOOT ignores stall
    #2 rst_a = 1'b0;
    #1 chk_a("asyncrst", BASE, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk); rst_a = 1'b1; stall_a = 1'b1;
    tick(); chk_a("reboot", BASE, 32'd0, 32'd0, 1'b0, 1'b0);
    stall_a = 1'b0;
    tick(); chk_a("rerun", 32'h0004_0004, SIG + 32'd0, 32'h0004_0004, 1'b1, 1'b0);

    // Test 5: 4-word window, run off the end
    rst_b = 1'b1;
    tick(); chk_b("b.boot", BASE, 32'd0, 32'd0, 1'b0, 1'b0);
    tick(); check("b.pc1", pc_b, 32'h0004_0004);
    tick(); check("b.pc2", pc_b, 32'h0004_0008);
    tick(); chk_b("b.w2", 32'h0004_000C, SIG + 32'd2, 32'h0004_000C, 1'b1, 1'b0);
    tick(); chk_b("b.last", 32'h0004_000C, SIG + 32'd3, 32'h0004_0010, 1'b1, 1'b1);
    tick(); chk_b("b.halt", 32'h0004_000C, 32'd0, 32'd0, 1'b0, 1'b1);

    // Below-window redirect during BOOT
    #2 rst_b = 1'b0;
    @(negedge clk); rst_b = 1'b1; redir_b = 1'b1; tgt_b = 32'h0003_FFFC;
    tick(); chk_b("b.below", BASE, 32'd0, 32'd0, 1'b0, 1'b1);
    redir_b = 1'b0;

    // Legal redirect to last word in BOOT, then advance faults
    #2 rst_b = 1'b0;
    @(negedge clk); rst_b = 1'b1; redir_b = 1'b1; tgt_b = 32'h0004_000C;
    tick(); chk_b("b.tolast", 32'h0004_000C, 32'd0, 32'd0, 1'b0, 1'b0);
    redir_b = 1'b0;
    tick(); chk_b("b.lastadv", 32'h0004_000C, SIG + 32'd3, 32'h0004_0010, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
